// File: rtl/dma_desc_sched.sv
// dma_desc_sched: shares one descriptor streamer among NUM_CH DMA channels.
// Round-robin arbitration; the grant is held until the streamer reports done,
// the transfer is aborted, or the per-transfer watchdog expires.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid_i   per-channel request, held until that channel's done/err pulse
//   req_idx_i     per-channel descriptor index, channel i at [i*IDX_W +: IDX_W]
//   abort_i       level abort: ends the current transfer, blocks new grants
//   ch_done_o     one-cycle pulse, granted transfer completed
//   ch_err_o      one-cycle pulse, granted transfer aborted or timed out
//   str_valid_o   streamer request valid (high for the whole transfer)
//   str_idx_o     descriptor index latched at grant time
//   str_done_i    streamer completion pulse
//   grant_ch_o    currently (or most recently) granted channel
//   busy_o        transfer in progress
//   tmo_o         sticky watchdog flag, cleared by rst or abort_i
module dma_desc_sched #(
  parameter  int NUM_CH  = 4,
  parameter  int IDX_W   = 3,
  parameter  int TMO_W   = 16,
  parameter  int TIMEOUT = 1000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH*IDX_W-1:0] req_idx_i,
  input  logic                    abort_i,
  output logic [NUM_CH-1:0]       ch_done_o,
  output logic [NUM_CH-1:0]       ch_err_o,
  output logic                    str_valid_o,
  output logic [IDX_W-1:0]        str_idx_o,
  input  logic                    str_done_i,
  output logic [CH_W-1:0]         grant_ch_o,
  output logic                    busy_o,
  output logic                    tmo_o
);

  typedef enum logic {ARB, BUSY} state_e;

  localparam bit               WD_EN    = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] done_q, done_d, err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  // Round-robin pick: first requester after rr_q, wrapping.
  logic              pick_vld;
  logic [CH_W-1:0]   pick_ch, cand;
  logic [IDX_W-1:0]  pick_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_ch  = cand;
      end
    end
    pick_idx = req_idx_i[int'(pick_ch)*IDX_W +: IDX_W];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    tmo_d   = abort_i ? 1'b0 : tmo_q;
    case (state_q)
      ARB: begin
        if (!abort_i && pick_vld) begin
          state_d = BUSY;
          grant_d = pick_ch;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // done beats abort beats watchdog
        if (str_done_i) begin
          done_d[grant_q] = 1'b1;
          rr_d            = grant_q;
          state_d         = ARB;
        end else if (abort_i) begin
          err_d[grant_q] = 1'b1;
          rr_d           = grant_q;
          state_d        = ARB;
        end else if (WD_EN && cnt_q == CNT_LAST) begin
          err_d[grant_q] = 1'b1;
          tmo_d          = 1'b1;
          rr_d           = grant_q;
          state_d        = ARB;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;  // saturating
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= CH_W'(NUM_CH - 1);
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign str_valid_o = (state_q == BUSY);
  assign busy_o      = (state_q == BUSY);
  assign str_idx_o   = idx_q;
  assign grant_ch_o  = grant_q;
  assign ch_done_o   = done_q;
  assign ch_err_o    = err_q;
  assign tmo_o       = tmo_q;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level model.
module tb_dma_desc_sched;
  localparam int N   = 4;
  localparam int IW  = 3;
  localparam int TW  = 16;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, abort, sd;
  logic [N-1:0]    req;
  logic [N*IW-1:0] ridx;
  logic [N-1:0]    done_o, err_o;
  logic            sv, busy, tmo;
  logic [IW-1:0]   sidx;
  logic [1:0]      gch;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit cmp_en  = 1'b0;

  dma_desc_sched #(.NUM_CH(N), .IDX_W(IW), .TMO_W(TW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req), .req_idx_i(ridx), .abort_i(abort),
    .ch_done_o(done_o), .ch_err_o(err_o), .str_valid_o(sv), .str_idx_o(sidx),
    .str_done_i(sd), .grant_ch_o(gch), .busy_o(busy), .tmo_o(tmo)
  );

  // Transaction-level model: "in a transfer or not", who owns it, how many
  // BUSY cycles have elapsed, and the pulses/flags the last edge produced.
  typedef struct {
    bit          busy;
    int          grant;
    int          idx;
    int          cnt;
    int          rr;
    logic [N-1:0] done;
    logic [N-1:0] err;
    bit          tmo;
  } model_t;

  model_t mdl;

  function automatic model_t step(model_t m, logic r, logic [N-1:0] rq,
                                  logic [N*IW-1:0] ri, logic ab, logic d);
    model_t n = m;
    n.done = '0;
    n.err  = '0;
    if (r) begin
      n.busy = 0; n.grant = 0; n.idx = 0; n.cnt = 0; n.rr = N - 1; n.tmo = 0;
      return n;
    end
    if (ab) n.tmo = 0;
    if (!m.busy) begin
      if (!ab) begin
        for (int k = 1; k <= N; k++) begin
          int c = (m.rr + k) % N;
          if (rq[c]) begin
            n.busy = 1; n.grant = c; n.idx = int'(ri[c*IW +: IW]); n.cnt = 0;
            break;
          end
        end
      end
    end else if (d) begin
      n.done[m.grant] = 1'b1; n.busy = 0; n.rr = m.grant;
    end else if (ab) begin
      n.err[m.grant] = 1'b1; n.busy = 0; n.rr = m.grant;
    end else if (m.cnt + 1 >= TMO) begin
      // this is the TMO-th BUSY cycle without completion
      n.err[m.grant] = 1'b1; n.busy = 0; n.rr = m.grant; n.tmo = 1;
    end else begin
      n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk) mdl <= step(mdl, rst, req, ridx, abort, sd);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_str_valid", 32'(sv),     32'(mdl.busy));
      chk("m_busy",      32'(busy),   32'(mdl.busy));
      chk("m_grant",     32'(gch),    32'(mdl.grant));
      chk("m_str_idx",   32'(sidx),   32'(mdl.idx));
      chk("m_done",      32'(done_o), 32'(mdl.done));
      chk("m_err",       32'(err_o),  32'(mdl.err));
      chk("m_tmo",       32'(tmo),    32'(mdl.tmo));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] fin;

  initial begin
    rst = 1'b1; abort = 1'b0; sd = 1'b0; req = '0; ridx = '0;
    cyc(); cyc();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_str_valid", 32'(sv), 0);
    chk("rst_grant", 32'(gch), 0);
    chk("rst_idx", 32'(sidx), 0);
    chk("rst_pulses", 32'({done_o, err_o}), 0);
    chk("rst_tmo", 32'(tmo), 0);

    // Single requester, done three cycles into the transfer
    req = 4'b0010; ridx = 12'o0050;
    cyc();
    chk("single_valid", 32'(sv), 1);
    chk("single_idx", 32'(sidx), 5);
    chk("single_grant", 32'(gch), 1);
    ridx = 12'o7777;  // later index changes must not leak through
    cyc(); cyc();
    chk("single_idx_held", 32'(sidx), 5);
    sd = 1'b1;
    cyc();
    sd = 1'b0;
    chk("single_done", 32'(done_o), 32'h2);
    chk("single_valid_low", 32'(sv), 0);
    req = '0;
    cyc();
    chk("single_done_one_cycle", 32'(done_o), 0);

    // Round robin from a fresh reset
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'b1111; ridx = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk("rr_grant", 32'(gch), 32'(g % 4));
      chk("rr_idx", 32'(sidx), 32'(g % 4 + 1));
      sd = 1'b1;
      cyc();
      sd = 1'b0;
      chk("rr_gap", 32'(sv), 0);
      chk("rr_done", 32'(done_o), 32'(1 << (g % 4)));
    end
    req = '0;
    cyc();

    // Watchdog: channel 2, no completion
    req = 4'b0100;
    cyc();
    chk("tmo_grant", 32'(gch), 2);
    for (int k = 0; k < TMO - 1; k++) begin
      cyc();
      chk("tmo_still_busy", 32'(sv), 1);
    end
    cyc();
    chk("tmo_err", 32'(err_o), 32'h4);
    chk("tmo_flag", 32'(tmo), 1);
    chk("tmo_valid_low", 32'(sv), 0);
    req = 4'b1001;
    cyc();
    chk("tmo_next_grant", 32'(gch), 3);
    chk("tmo_sticky", 32'(tmo), 1);
    sd = 1'b1; cyc(); sd = 1'b0;
    req = '0;
    cyc();

    // Abort mid-transfer, held five cycles
    req = 4'b0011;
    cyc();
    chk("abort_grant", 32'(gch), 0);
    cyc();
    abort = 1'b1;
    cyc();
    chk("abort_err", 32'(err_o), 32'h1);
    chk("abort_tmo_clear", 32'(tmo), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("abort_no_grant", 32'(sv), 0);
    end
    abort = 1'b0;
    cyc();
    chk("abort_resume_grant", 32'(gch), 1);
    chk("abort_resume_valid", 32'(sv), 1);
    sd = 1'b1; cyc(); sd = 1'b0;
    req = '0;
    cyc();

    // done and abort together: done wins
    req = 4'b0100;
    cyc();
    sd = 1'b1; abort = 1'b1;
    cyc();
    sd = 1'b0; abort = 1'b0;
    chk("coll_done", 32'(done_o), 32'h4);
    chk("coll_err", 32'(err_o), 0);
    req = '0;
    cyc();

    // Reset while busy
    req = 4'b1111;
    cyc();
    chk("rstb_grant", 32'(gch), 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstb_valid", 32'(sv), 0);
    chk("rstb_grant0", 32'(gch), 0);
    chk("rstb_pulses", 32'({done_o, err_o}), 0);
    cyc();
    chk("rstb_regrant", 32'(gch), 0);
    sd = 1'b1; cyc(); sd = 1'b0;
    req = '0;
    cyc();

    // Random traffic; requesters hold until their own pulse
    for (int t = 0; t < 3000; t++) begin
      fin = mdl.done | mdl.err;
      for (int i = 0; i < N; i++) begin
        if (req[i] && fin[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      ridx  = N*IW'($urandom);
      sd    = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; abort = 1'b0; sd = 1'b0; req = '0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
